gate_weight_loader: RTL and testbench

GATE_WEIGHT_LOADER -- requirements
Module: gate_weight_loader

---
 rtl/gate_weight_loader_if.sv | 16 +
 rtl/gate_weight_loader.sv | 197 +++++++++++++++++++
 tb/tb_gate_weight_loader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_weight_loader_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gate_weight_loader_if: valid/ready weight stream into the loader |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface gate_weight_loader_if #(
  parameter int BITWIDTH = 18
);
  logic [BITWIDTH-1:0] s_data;
  logic                s_valid;
  logic                s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface
`default_nettype wire

// File: rtl/gate_weight_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gate_weight_loader: streams Wx/Wy columns and bias into a gate,  |
// | then kicks it. Optional trailing checksum word: LOADER_CHECKSUM_EN|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module gate_weight_loader #(
  parameter int  INPUT_SZ       = 4,
  parameter int  HIDDEN_SZ      = 32,
  parameter int  QN             = 6,
  parameter int  QM             = 11,
  localparam int BITWIDTH       = QN + QM + 1,
  localparam int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ,
  localparam int ADDR_X         = $clog2(INPUT_SZ),
  localparam int ADDR_Y         = $clog2(HIDDEN_SZ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  gate_weight_loader_if.slave       s,
  output logic [ADDR_X-1:0]         colAddressWrite_X,
  output logic                      writeEn_X,
  output logic [LAYER_BITWIDTH-1:0] weightMemInput_X,
  output logic [ADDR_Y-1:0]         colAddressWrite_Y,
  output logic                      writeEn_Y,
  output logic [LAYER_BITWIDTH-1:0] weightMemInput_Y,
  output logic [LAYER_BITWIDTH-1:0] biasVec,
  output logic                      gateReset,
  output logic                      beginCalc,
`ifdef LOADER_CHECKSUM_EN
  output logic                      checksumError,
`endif
  output logic                      busy
);

  localparam int K_W = (ADDR_X > ADDR_Y) ? ADDR_X : ADDR_Y;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_WX = 3'd1,
    LOAD_WY = 3'd2,
    LOAD_B  = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    CHECK   = 3'd5,
`endif
    KICK    = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_Y-1:0]         l_q, l_d;
  logic [K_W-1:0]            k_q, k_d;
  logic [LAYER_BITWIDTH-1:0] col_x_q, col_y_q, bias_q;
  logic                      wen_x_q, wen_y_q;
  logic [ADDR_X-1:0]         addr_x_q;
  logic [ADDR_Y-1:0]         addr_y_q;
  logic                      loading, accept, last_row, last_x_col, last_y_col;

  assign loading    = (state_q != IDLE) && (state_q != KICK);
  assign accept     = loading && s.s_valid;
  assign last_row   = (l_q == ADDR_Y'(HIDDEN_SZ - 1));
  assign last_x_col = (k_q == K_W'(INPUT_SZ - 1));
  assign last_y_col = (k_q == K_W'(HIDDEN_SZ - 1));

  assign s.s_ready         = loading;
  assign gateReset         = loading;
  assign busy              = (state_q != IDLE);
  assign beginCalc         = (state_q == KICK);
  assign writeEn_X         = wen_x_q;
  assign writeEn_Y         = wen_y_q;
  assign colAddressWrite_X = addr_x_q;
  assign colAddressWrite_Y = addr_y_q;
  assign weightMemInput_X  = col_x_q;
  assign weightMemInput_Y  = col_y_q;
  assign biasVec           = bias_q;

`ifdef LOADER_CHECKSUM_EN
  logic [BITWIDTH-1:0] sum_q;
  logic                err_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      l_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_WX;
          l_d     = '0;
          k_d     = '0;
        end
      end
      LOAD_WX, LOAD_WY, LOAD_B: begin
        if (accept) begin
          l_d = last_row ? '0 : l_q + ADDR_Y'(1);
          if (last_row) begin
            k_d = k_q + K_W'(1);
            if (state_q == LOAD_WX && last_x_col) begin
              state_d = LOAD_WY;
              k_d     = '0;
            end
            if (state_q == LOAD_WY && last_y_col) begin
              state_d = LOAD_B;
              k_d     = '0;
            end
            if (state_q == LOAD_B) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = CHECK;
`else
              state_d = KICK;
`endif
              k_d     = '0;
            end
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) state_d = (s.s_data == sum_q) ? KICK : IDLE;
      end
`endif
      KICK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Column registers feed the RAM directly; a word taken during a strobe
  // cycle lands in slot 0 only after that edge, so the RAM sees the full column.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_x_q  <= '0;
      col_y_q  <= '0;
      bias_q   <= '0;
      wen_x_q  <= 1'b0;
      wen_y_q  <= 1'b0;
      addr_x_q <= '0;
      addr_y_q <= '0;
    end else begin
      wen_x_q <= 1'b0;
      wen_y_q <= 1'b0;
      if (accept) begin
        case (state_q)
          LOAD_WX: begin
            col_x_q[l_q*BITWIDTH +: BITWIDTH] <= s.s_data;
            if (last_row) begin
              wen_x_q  <= 1'b1;
              addr_x_q <= k_q[ADDR_X-1:0];
            end
          end
          LOAD_WY: begin
            col_y_q[l_q*BITWIDTH +: BITWIDTH] <= s.s_data;
            if (last_row) begin
              wen_y_q  <= 1'b1;
              addr_y_q <= k_q[ADDR_Y-1:0];
            end
          end
          LOAD_B:  bias_q[l_q*BITWIDTH +: BITWIDTH] <= s.s_data;
          default: ;
        endcase
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      if (state_q == CHECK) begin
        if (s.s_data != sum_q) err_q <= 1'b1;
      end else begin
        sum_q <= sum_q + s.s_data;
      end
    end
  end

  assign checksumError = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_weight_loader.sv
`default_nettype none
// Randomised bench for gate_weight_loader against a word-index based reference model.
module tb_gate_weight_loader;
  localparam int IS  = 4;
  localparam int HS  = 32;
  localparam int BW  = 18;
  localparam int LBW = BW * HS;
  localparam int NX  = IS * HS;
  localparam int NY  = HS * HS;
  localparam int NB  = HS;
`ifdef LOADER_CHECKSUM_EN
  localparam int NW  = NX + NY + NB + 1;
`else
  localparam int NW  = NX + NY + NB;
`endif
  localparam int GAPIDX = NX + 7 * HS + 16;

  logic           clock = 1'b0;
  logic           reset, start;
  logic [1:0]     colAddressWrite_X;
  logic [4:0]     colAddressWrite_Y;
  logic           writeEn_X, writeEn_Y, gateReset, beginCalc, busy;
  logic [LBW-1:0] weightMemInput_X, weightMemInput_Y, biasVec;
`ifdef LOADER_CHECKSUM_EN
  logic           checksumError;
`endif

  gate_weight_loader_if #(.BITWIDTH(BW)) sif ();

  gate_weight_loader #(.INPUT_SZ(IS), .HIDDEN_SZ(HS), .QN(6), .QM(11)) dut (
    .clock(clock), .reset(reset), .start(start), .s(sif),
    .colAddressWrite_X(colAddressWrite_X), .writeEn_X(writeEn_X),
    .weightMemInput_X(weightMemInput_X),
    .colAddressWrite_Y(colAddressWrite_Y), .writeEn_Y(writeEn_Y),
    .weightMemInput_Y(weightMemInput_Y),
    .biasVec(biasVec), .gateReset(gateReset), .beginCalc(beginCalc),
`ifdef LOADER_CHECKSUM_EN
    .checksumError(checksumError),
`endif
    .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit chk_on   = 0;

  task automatic chk(input string nm, input logic [LBW-1:0] act, input logic [LBW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: tracks the sequence position of each accepted word.
  bit             m_load, m_kick, m_wx, m_wy, m_err, m_idle;
  int             m_n, m_ax, m_ay;
  logic [LBW-1:0] m_x, m_y, m_b;
  logic [BW-1:0]  m_sum;

  task automatic model_accept(input logic [BW-1:0] w);
    int r, c;
    if (m_n < NX) begin
      r = m_n % HS; c = m_n / HS;
      m_x[r*BW +: BW] = w;
      if (r == HS - 1) begin m_wx = 1; m_ax = c; end
    end else if (m_n < NX + NY) begin
      r = (m_n - NX) % HS; c = (m_n - NX) / HS;
      m_y[r*BW +: BW] = w;
      if (r == HS - 1) begin m_wy = 1; m_ay = c; end
    end else if (m_n < NX + NY + NB) begin
      m_b[(m_n - NX - NY)*BW +: BW] = w;
    end else if (w != m_sum) begin
      m_err = 1;
    end
    m_sum = m_sum + w;
    m_n++;
    if (m_n == NW) begin
      m_load = 0;
      m_kick = !m_err;
    end
  endtask

  always @(posedge clock) begin
    cyc++;
    chk_on = 1;
    if (reset) begin
      m_load = 0; m_kick = 0; m_wx = 0; m_wy = 0; m_err = 0;
      m_n = 0; m_ax = 0; m_ay = 0; m_x = '0; m_y = '0; m_b = '0; m_sum = '0;
    end else begin
      m_idle = !m_load && !m_kick;
      m_wx = 0; m_wy = 0; m_kick = 0;
      if (m_idle) begin
        if (start) begin m_load = 1; m_n = 0; m_sum = '0; m_err = 0; end
      end else if (m_load && sif.s_valid) begin
        model_accept(sif.s_data);
      end
    end
  end

  int cnt_wx, cnt_wy, cnt_y7, cnt_bc, bc_cyc, last_edge;

  always @(negedge clock) begin
    if (chk_on) begin
      chk("s_ready", sif.s_ready, m_load);
      chk("gateReset", gateReset, m_load);
      chk("busy", busy, m_load || m_kick);
      chk("beginCalc", beginCalc, m_kick);
      chk("writeEn_X", writeEn_X, m_wx);
      chk("writeEn_Y", writeEn_Y, m_wy);
      if (m_wx) chk("addr_X", colAddressWrite_X, m_ax);
      if (m_wy) chk("addr_Y", colAddressWrite_Y, m_ay);
      chk("colX", weightMemInput_X, m_x);
      chk("colY", weightMemInput_Y, m_y);
      chk("biasVec", biasVec, m_b);
`ifdef LOADER_CHECKSUM_EN
      chk("checksumError", checksumError, m_err);
`endif
      if (writeEn_X) cnt_wx++;
      if (writeEn_Y) cnt_wy++;
      if (writeEn_Y && colAddressWrite_Y == 5'd7) cnt_y7++;
      if (beginCalc) begin cnt_bc++; bc_cyc = cyc; end
    end
  end

  logic [BW-1:0] seq [NW];

  task automatic fill_seq(input bit rnd, input int delta);
    logic [BW-1:0] s;
    s = '0;
    for (int i = 0; i < NW; i++) begin
      seq[i] = rnd ? BW'($urandom) : BW'(i);
      if (i < NX + NY + NB) s = s + seq[i];
    end
`ifdef LOADER_CHECKSUM_EN
    seq[NW-1] = s + BW'(delta);
`else
    if (delta != 0) seq[0] = s;
`endif
  endtask

  task automatic clr_counts();
    #1;
    cnt_wx = 0; cnt_wy = 0; cnt_y7 = 0; cnt_bc = 0; bc_cyc = -1; last_edge = -2;
  endtask

  // gap: 0 none, 1 random, 2 five-cycle hole at GAPIDX. Called at a negedge.
  task automatic run_load(input int gap, input bit glitch, input int abort_at, output int len);
    int idx, budget, t0, hole;
    bit v;
    clr_counts();
    @(negedge clock);
    start = 1; t0 = cyc + 1;
    @(negedge clock);
    start = 0; idx = 0; budget = 0; hole = 5;
    while (idx < NW && budget < 4 * NW) begin
      if (abort_at >= 0 && idx == abort_at) break;
      v = 1;
      if (gap == 1) v = ($urandom_range(0, 3) != 0);
      if (gap == 2 && idx == GAPIDX && hole > 0) begin v = 0; hole--; end
      sif.s_valid = v;
      sif.s_data  = seq[idx];
      start = glitch && idx >= NX && idx < NX + NY && (idx % 37 == 0);
      if (v && sif.s_ready) begin
        idx++;
        if (idx == NW) last_edge = cyc + 1;
      end
      @(negedge clock);
      budget++;
    end
    start = 0;
    if (abort_at >= 0) begin
      reset = 1; start = 1; sif.s_valid = 1;
      @(negedge clock);
      reset = 0; start = 0; sif.s_valid = 0;
      chk("rst_ready", sif.s_ready, 0);
      chk("rst_wen", {writeEn_X, writeEn_Y, beginCalc, gateReset, busy}, 0);
      chk("rst_addr", {colAddressWrite_X, colAddressWrite_Y}, 0);
      chk("rst_cols", weightMemInput_X | weightMemInput_Y | biasVec, 0);
      len = 0;
    end else begin
      sif.s_valid = 0;
      chk("words_accepted", idx, NW);
      repeat (3) @(negedge clock);
      len = last_edge - t0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int len1, len2, lenx;

  initial begin
    reset = 1; start = 0; sif.s_valid = 0; sif.s_data = '0;
    repeat (3) @(negedge clock);
    chk("reset_outs", {sif.s_ready, writeEn_X, writeEn_Y, beginCalc, gateReset, busy,
                       colAddressWrite_X, colAddressWrite_Y}, 0);
    chk("reset_data", weightMemInput_X | weightMemInput_Y | biasVec, 0);
    reset = 0;

    // Index-valued stream, no gaps.
    fill_seq(0, 0);
    run_load(0, 0, -1, len1);
    chk("cnt_wx", cnt_wx, 4);
    chk("cnt_wy", cnt_wy, 32);
    chk("cnt_begin", cnt_bc, 1);
    chk("begin_cycle", bc_cyc, last_edge);
    for (int l = 0; l < HS; l++) chk("bias_elem", biasVec[l*BW +: BW], 1152 + l);
    chk("lastX_row31", weightMemInput_X[31*BW +: BW], 127);
    chk("lastY_row31", weightMemInput_Y[31*BW +: BW], 1151);

    // Five-cycle hole inside Wy column 7.
    run_load(2, 0, -1, len2);
    chk("gap_len", len2, len1 + 5);
    chk("gap_y7_once", cnt_y7, 1);
    chk("gap_cnt_wy", cnt_wy, 32);

    // Abort with reset after 50 words, then a clean reload.
    fill_seq(1, 0);
    run_load(0, 0, 50, lenx);
    clr_counts();
    repeat (10) @(negedge clock);
    chk("abort_strobes", cnt_wx + cnt_wy, 0);
    chk("abort_begin", cnt_bc, 0);
    run_load(1, 0, -1, lenx);
    chk("reload_begin", cnt_bc, 1);

    // start pulsed while loading Wy.
    fill_seq(1, 0);
    run_load(0, 1, -1, lenx);
    chk("glitch_wx", cnt_wx, 4);
    chk("glitch_wy", cnt_wy, 32);
    chk("glitch_begin", cnt_bc, 1);

    for (int t = 0; t < 2; t++) begin
      fill_seq(1, 0);
      run_load(1, 0, -1, lenx);
      chk("rand_begin", cnt_bc, 1);
    end

`ifdef LOADER_CHECKSUM_EN
    fill_seq(1, 1);
    run_load(1, 0, -1, lenx);
    chk("cks_bad_begin", cnt_bc, 0);
    chk("cks_bad_err", checksumError, 1);
    fill_seq(1, 0);
    run_load(0, 0, -1, lenx);
    chk("cks_ok_begin", cnt_bc, 1);
    chk("cks_ok_err", checksumError, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
`default_nettype wire
